// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//
// Purpose:
//   Multi-cycle WIDTH-bit magnitude comparator. Two operands are captured on a
//   valid/ready handshake. They are then compared most-significant slice first,
//   DIGIT bits per clock. The first slice that differs decides the result. The
//   result is held on o_A_LT_B / o_A_EQ_B / o_A_GT_B with o_VALID until the
//   consumer accepts it. Exactly one flag is high while o_VALID is high.
//   Signed (two's-complement) compares flip the sign bit of both operands at
//   capture and then reuse the unsigned datapath.
//
// Parameters:
//   WIDTH  operand width in bits. Must be a multiple of DIGIT.
//   DIGIT  bits compared per clock. S = WIDTH/DIGIT slices per operation.
//
// Ports:
//   i_CLK        clock; all state changes on the rising edge
//   i_RST_N      asynchronous active-low reset
//   i_VALID      operation request
//   o_READY      block can accept a request (IDLE only)
//   i_OPERAND_A  operand A (sampled only at the accept edge)
//   i_OPERAND_B  operand B (sampled only at the accept edge)
//   i_SIGNED     1 = two's-complement compare, 0 = unsigned compare
//   o_VALID      result available
//   i_READY      consumer accepts the result
//   o_A_LT_B     A <  B
//   o_A_EQ_B     A == B
//   o_A_GT_B     A >  B
//
// Configuration macro:
//   SERIAL_CMP_EARLY_EXIT_EN
//     defined     : RUN ends on the edge that compares the first differing
//                   slice (latency k+1 for first difference at slice k).
//                   Equal operands still take S cycles.
//     not defined : RUN always performs all S slice compares (latency S).
// -----------------------------------------------------------------------------
module serial_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    input  logic             i_SIGNED,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_A_LT_B,
    output logic             o_A_EQ_B,
    output logic             o_A_GT_B
);

    localparam int S     = WIDTH / DIGIT;
    localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic               ready_q,  ready_d;
    logic               valid_q,  valid_d;
    logic               lt_q,     lt_d;
    logic               eq_q,     eq_d;
    logic               gt_q,     gt_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    // Operand shift registers: the slice under comparison is always the top
    // DIGIT bits, so no variable-index mux is needed on the wide operands.
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    // Sticky decision accumulated across slices.
    logic               acc_lt_q, acc_lt_d;
    logic               acc_gt_q, acc_gt_d;

    // -------------------------------------------------------------------------
    // Current slice extraction
    // -------------------------------------------------------------------------
    logic [DIGIT-1:0]   slice_a;
    logic [DIGIT-1:0]   slice_b;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_slice
            assign slice_a[gi] = a_q[WIDTH-DIGIT+gi];
            assign slice_b[gi] = b_q[WIDTH-DIGIT+gi];
        end
    endgenerate

    logic slice_lt;
    logic slice_gt;
    logic decided;
    logic new_lt;
    logic new_gt;
    logic last_slice;
    logic finish_run;
    logic accept;

    assign slice_lt   = (slice_a < slice_b);
    assign slice_gt   = (slice_a > slice_b);
    assign decided    = acc_lt_q | acc_gt_q;
    // Once a slice has differed, later slices cannot change the outcome.
    assign new_lt     = acc_lt_q | (~decided & slice_lt);
    assign new_gt     = acc_gt_q | (~decided & slice_gt);
    assign last_slice = (idx_q == LAST_IDX);
    // ready_q (not the state) gates the handshake, so nothing is accepted in
    // the cycle between reset release and the first rising edge.
    assign accept     = i_VALID & ready_q;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign finish_run = last_slice | new_lt | new_gt;
`else
    assign finish_run = last_slice;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_lt_d = acc_lt_q;
        acc_gt_d = acc_gt_q;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    // Flipping the sign bit maps two's-complement order onto
                    // unsigned order, so one datapath serves both modes.
                    a_d      = i_OPERAND_A ^ (i_SIGNED ? MSB_MASK : '0);
                    b_d      = i_OPERAND_B ^ (i_SIGNED ? MSB_MASK : '0);
                    idx_d    = '0;
                    acc_lt_d = 1'b0;
                    acc_gt_d = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                ready_d  = 1'b0;
                a_d      = a_q << DIGIT;
                b_d      = b_q << DIGIT;
                idx_d    = idx_q + IDX_W'(1);
                acc_lt_d = new_lt;
                acc_gt_d = new_gt;
                if (finish_run) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    lt_d    = new_lt;
                    gt_d    = new_gt;
                    eq_d    = ~(new_lt | new_gt);
                end
            end

            ST_DONE: begin
                ready_d = 1'b0;
                if (i_READY) begin
                    // Flags are left holding the last result on purpose.
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_lt_q <= 1'b0;
            acc_gt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_lt_q <= acc_lt_d;
            acc_gt_q <= acc_gt_d;
        end
    end

    assign o_READY  = ready_q;
    assign o_VALID  = valid_q;
    assign o_A_LT_B = lt_q;
    assign o_A_EQ_B = eq_q;
    assign o_A_GT_B = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// Testbench for serial_magnitude_comparator (WIDTH=32, DIGIT=4, S=8).
// Directed vectors push their hand-computed flags and latency into a
// scoreboard queue; an independent monitor pops and compares each time the
// DUT raises o_VALID. Build with +define+SERIAL_CMP_EARLY_EXIT_EN to check
// the early-exit latencies.
// -----------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

    localparam int W = 32;
    localparam int D = 4;
    localparam int S = W / D;

    localparam logic [2:0] F_LT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_signed;
    logic          out_valid;
    logic          in_ready;
    logic          a_lt_b;
    logic          a_eq_b;
    logic          a_gt_b;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_VALID     (in_valid),
        .o_READY     (out_ready),
        .i_OPERAND_A (op_a),
        .i_OPERAND_B (op_b),
        .i_SIGNED    (op_signed),
        .o_VALID     (out_valid),
        .i_READY     (in_ready),
        .o_A_LT_B    (a_lt_b),
        .o_A_EQ_B    (a_eq_b),
        .o_A_GT_B    (a_gt_b)
    );

    typedef struct {
        string      name;
        logic [2:0] flags;
        int         lat;
        int         t;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected cycles from accept edge to o_VALID; k = first differing slice.
    function automatic int exp_lat(input logic [2:0] f, input int k);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return (f == F_EQ) ? S : k + 1;
`else
        if (f == F_EQ) return S;
        return S + 0 * k;
`endif
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic prev_v;
        exp_t e;
        int   lat;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_valid: got o_VALID=1 flags=%b, expected no result", {a_lt_b, a_eq_b, a_gt_b});
                    end else begin
                        e   = sb_q.pop_front();
                        lat = cyc - e.t;
                        $display("txn %s: flags(lt,eq,gt)=%b expected %b latency=%0d expected %0d",
                                 e.name, {a_lt_b, a_eq_b, a_gt_b}, e.flags, lat, e.lat);
                        check({e.name, "_flags"}, 32'({a_lt_b, a_eq_b, a_gt_b}), 32'(e.flags));
                        check({e.name, "_latency"}, 32'(lat), 32'(e.lat));
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] f, input int k);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!out_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_ready) begin
            check({name, "_ready_timeout"}, 32'(out_ready), 32'd1);
            return;
        end
        op_a      = a;
        op_b      = b;
        op_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.name   = name;
        e.flags  = f;
        e.lat    = exp_lat(f, k);
        e.t      = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_ready) check({name, "_idle_timeout"}, 32'(out_ready), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [2:0] f, input int k);
        issue(name, a, b, s, f, k);
        wait_idle(name);
    endtask

    // ------------------------------------------------------------------ main
    initial begin : main
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_signed = 1'b0;
        in_ready  = 1'b1;

        #2;
        check("reset_ready", 32'(out_ready), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_flags", 32'({a_lt_b, a_eq_b, a_gt_b}), 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(out_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 32'(out_ready), 32'd1);

        // Directed vectors: name, A, B, signed, flags, first differing slice
        run_op("u_small_lt",    32'h0000000D, 32'h0000000F, 1'b0, F_LT, 7);
        run_op("u_msb_gt",      32'hF0000000, 32'h10000000, 1'b0, F_GT, 0);
        run_op("s_msb_lt",      32'hF0000000, 32'h10000000, 1'b1, F_LT, 0);
        run_op("u_ones_gt",     32'hFFFFFFFF, 32'h00000001, 1'b0, F_GT, 0);
        run_op("s_ones_lt",     32'hFFFFFFFF, 32'h00000001, 1'b1, F_LT, 0);
        run_op("eq_deadbeef",   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, F_EQ, 0);
        run_op("s_eq_deadbeef", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, F_EQ, 0);
        run_op("u_mid_gt",      32'h00050000, 32'h00040000, 1'b0, F_GT, 3);
        run_op("s_min_lt",      32'h80000000, 32'h7FFFFFFF, 1'b1, F_LT, 0);
        run_op("u_min_gt",      32'h80000000, 32'h7FFFFFFF, 1'b0, F_GT, 0);
        run_op("s_neg_lt",      32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, F_LT, 7);
        run_op("u_lsb_gt",      32'h12345679, 32'h12345678, 1'b0, F_GT, 7);

        // Backpressure: result held, o_READY low, new request ignored
        in_ready = 1'b0;
        issue("bp_gt", 32'h00050000, 32'h00040000, 1'b0, F_GT, 3);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_flags", 32'({a_lt_b, a_eq_b, a_gt_b}), 32'(F_GT));
            check("bp_hold_ready", 32'(out_ready), 32'd0);
            if (i == 1) begin
                op_a      = 32'h00000000;
                op_b      = 32'hFFFFFFFF;
                op_signed = 1'b0;
                in_valid  = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(out_ready), 32'd1);
        check("bp_flags_hold_after", 32'({a_lt_b, a_eq_b, a_gt_b}), 32'(F_GT));
        repeat (S + 3) @(negedge clk);
        check("bp_ignored_no_valid", 32'(out_valid), 32'd0);
        check("bp_ignored_ready", 32'(out_ready), 32'd1);

        // Reset in the middle of RUN (slice index 3)
        issue("rst_abandon", 32'h0000000D, 32'h0000000F, 1'b0, F_LT, 7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("rst_mid_ready", 32'(out_ready), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_flags", 32'({a_lt_b, a_eq_b, a_gt_b}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        check("rst_no_stale_valid", 32'(out_valid), 32'd0);
        run_op("after_rst_lt", 32'h0000000D, 32'h0000000F, 1'b0, F_LT, 7);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
